// File: rtl/vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vend_ctrl
// Description : Vending transaction controller: credit tracking against a
//               price table, vend pulse, greedy coin-by-coin change, timeout
//               refund. Optional per-item stock tracking under VEND_STOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module vend_ctrl #(
    parameter  int NUM_GOODS   = 16,
    parameter  int MONEY_W     = 7,
    parameter  int MAX_CREDIT  = 99,
    parameter  int CHG_D2      = 10,
    parameter  int CHG_D1      = 5,
    parameter  int CHG_D0      = 1,
    parameter  int TIMEOUT_CYC = 1500000000,
    parameter  int STOCK_INIT  = 8,
    localparam int IDX_W       = (NUM_GOODS > 1) ? $clog2(NUM_GOODS) : 1
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         sel_valid,
    input  logic [IDX_W-1:0]             sel_idx,
    input  logic                         coin_valid,
    input  logic [MONEY_W-1:0]           coin_val,
    input  logic                         confirm,
    input  logic                         cancel,
    input  logic [NUM_GOODS*MONEY_W-1:0] price_tbl,
    input  logic                         change_ready,
    input  logic                         stock_restock,
    output logic [IDX_W-1:0]             goods_index,
    output logic [MONEY_W-1:0]           money,
    output logic                         enough_flag,
    output logic [1:0]                   money_flag,
    output logic                         vend_valid,
    output logic [IDX_W-1:0]             vend_idx,
    output logic                         change_valid,
    output logic [MONEY_W-1:0]           change_coin,
    output logic                         coin_reject,
    output logic                         sold_out,
    output logic                         busy
);

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0]    c_to_last    = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [MONEY_W:0]   c_max_credit = (MONEY_W+1)'(MAX_CREDIT);
    localparam logic [IDX_W:0]     c_num_goods  = (IDX_W+1)'(NUM_GOODS);
    localparam logic [MONEY_W-1:0] c_d2         = MONEY_W'(CHG_D2);
    localparam logic [MONEY_W-1:0] c_d1         = MONEY_W'(CHG_D1);
    localparam logic [MONEY_W-1:0] c_d0         = MONEY_W'(CHG_D0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEL    = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    state_t             r_state, w_state_nx;
    logic [MONEY_W-1:0] r_money, w_money_nx, w_credit, w_price;
    logic [MONEY_W:0]   w_sum;
    logic [IDX_W-1:0]   r_goods_index, w_goods_nx, r_vend_idx;
    logic [MONEY_W-1:0] r_change_coin;
    logic               r_vend_valid, r_change_valid, r_coin_reject, r_sold_out;
    logic [TO_W-1:0]    r_to_cnt;
    logic               w_open, w_coin_acc, w_sel_hit, w_empty, w_enough;
    logic               w_run, w_evt, w_timeout;
    logic [MONEY_W-1:0] w_price_arr [NUM_GOODS];

    function automatic logic [MONEY_W-1:0] f_greedy(input logic [MONEY_W-1:0] rem);
        if (rem >= c_d2) return c_d2;
        if (rem >= c_d1) return c_d1;
        return c_d0;
    endfunction

    for (genvar gp = 0; gp < NUM_GOODS; gp++) begin : g_price
        assign w_price_arr[gp] = price_tbl[gp*MONEY_W +: MONEY_W];
    end

    assign w_price    = w_price_arr[r_goods_index];
    assign w_enough   = (r_money >= w_price);
    assign w_open     = (r_state == ST_IDLE) || (r_state == ST_SEL);
    // Extra bit keeps the saturation check free of wrap-around.
    assign w_sum      = {1'b0, r_money} + {1'b0, coin_val};
    assign w_coin_acc = coin_valid && w_open && (w_sum <= c_max_credit);
    assign w_credit   = w_coin_acc ? w_sum[MONEY_W-1:0] : r_money;
    assign w_sel_hit  = sel_valid && w_open && !cancel && !confirm &&
                        ({1'b0, sel_idx} < c_num_goods);
    assign w_run      = (r_state == ST_SEL) || ((r_state == ST_IDLE) && (r_money != '0));
    assign w_evt      = sel_valid || coin_valid || confirm;
    assign w_timeout  = w_run && !w_evt && (r_to_cnt == c_to_last);

`ifdef VEND_STOCK_EN
    localparam int STK_W = $clog2(STOCK_INIT + 1);
    localparam logic [STK_W-1:0] c_stock_init = STK_W'(STOCK_INIT);
    logic [NUM_GOODS-1:0] w_empty_vec;

    for (genvar gi = 0; gi < NUM_GOODS; gi++) begin : g_stock
        logic [STK_W-1:0] r_stock;
        always_ff @(posedge sys_clk or posedge sys_rst) begin
            if (sys_rst) begin
                r_stock <= c_stock_init;
            end else if (stock_restock) begin
                r_stock <= c_stock_init;
            end else if (r_vend_valid && (r_vend_idx == IDX_W'(gi)) && (r_stock != '0)) begin
                r_stock <= r_stock - 1'b1;
            end
        end
        assign w_empty_vec[gi] = (r_stock == '0);
    end
    assign w_empty = w_empty_vec[sel_idx];
`else
    logic w_unused_restock;
    assign w_unused_restock = stock_restock;
    assign w_empty          = 1'b0;
`endif

    always_comb begin
        w_state_nx = r_state;
        w_money_nx = r_money;
        w_goods_nx = r_goods_index;
        case (r_state)
            ST_IDLE, ST_SEL: begin
                w_money_nx = w_credit;
                if (cancel || w_timeout) begin
                    w_state_nx = (w_credit != '0) ? ST_CHANGE : ST_IDLE;
                end else if (confirm) begin
                    // Affordability is judged on credit before any same-cycle coin.
                    if ((r_state == ST_SEL) && w_enough) w_state_nx = ST_VEND;
                end else if (w_sel_hit && !w_empty) begin
                    w_state_nx = ST_SEL;
                    w_goods_nx = sel_idx;
                end
            end
            ST_VEND: begin
                w_money_nx = w_enough ? (r_money - w_price) : '0;
                w_state_nx = (w_money_nx != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                if (r_change_valid && change_ready) begin
                    w_money_nx = r_money - r_change_coin;
                    if (w_money_nx == '0) w_state_nx = ST_IDLE;
                end else if (r_money == '0) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state        <= ST_IDLE;
            r_money        <= '0;
            r_goods_index  <= '0;
            r_vend_valid   <= 1'b0;
            r_vend_idx     <= '0;
            r_change_valid <= 1'b0;
            r_change_coin  <= '0;
            r_coin_reject  <= 1'b0;
            r_sold_out     <= 1'b0;
            r_to_cnt       <= '0;
        end else begin
            r_state        <= w_state_nx;
            r_money        <= w_money_nx;
            r_goods_index  <= w_goods_nx;
            r_vend_valid   <= (w_state_nx == ST_VEND);
            if (w_state_nx == ST_VEND) r_vend_idx <= r_goods_index;
            // Coin follows the remaining amount, so it is stable while ready is low.
            r_change_valid <= (w_state_nx == ST_CHANGE);
            r_change_coin  <= (w_state_nx == ST_CHANGE) ? f_greedy(w_money_nx) : '0;
            r_coin_reject  <= coin_valid && !w_coin_acc;
            r_sold_out     <= w_sel_hit && w_empty;
            r_to_cnt       <= (!w_run || w_evt || w_timeout) ? '0 : r_to_cnt + 1'b1;
        end
    end

    always_comb begin
        money_flag = 2'b00;
        case (r_state)
            ST_IDLE:   money_flag = 2'b00;
            ST_SEL:    money_flag = w_enough ? 2'b10 : 2'b01;
            ST_VEND:   money_flag = 2'b10;
            ST_CHANGE: money_flag = 2'b11;
            default:   money_flag = 2'b00;
        endcase
    end

    assign enough_flag  = (r_state == ST_SEL) && w_enough;
    assign busy         = (r_state == ST_VEND) || (r_state == ST_CHANGE);
    assign goods_index  = r_goods_index;
    assign money        = r_money;
    assign vend_valid   = r_vend_valid;
    assign vend_idx     = r_vend_idx;
    assign change_valid = r_change_valid;
    assign change_coin  = r_change_coin;
    assign coin_reject  = r_coin_reject;
    assign sold_out     = r_sold_out;

endmodule
`default_nettype wire

// File: tb/tb_vend_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vend_ctrl
// Description : Directed self-checking bench for vend_ctrl (timeout shortened
//               to 100 cycles, one unit of stock per item).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vend_ctrl;

    localparam int NG = 16;
    localparam int MW = 7;
    localparam int IW = 4;

    logic              sys_clk, sys_rst;
    logic              sel_valid, coin_valid, confirm, cancel;
    logic              change_ready, stock_restock;
    logic [IW-1:0]     sel_idx;
    logic [MW-1:0]     coin_val;
    logic [NG*MW-1:0]  price_tbl;
    logic [IW-1:0]     goods_index, vend_idx;
    logic [MW-1:0]     money, change_coin;
    logic [1:0]        money_flag;
    logic              enough_flag, vend_valid, change_valid;
    logic              coin_reject, sold_out, busy;

    int n_tests = 0;
    int n_fail  = 0;

    vend_ctrl #(
        .NUM_GOODS   (NG),
        .MONEY_W     (MW),
        .MAX_CREDIT  (99),
        .CHG_D2      (10),
        .CHG_D1      (5),
        .CHG_D0      (1),
        .TIMEOUT_CYC (100),
        .STOCK_INIT  (1)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst       (sys_rst),
        .sel_valid     (sel_valid),
        .sel_idx       (sel_idx),
        .coin_valid    (coin_valid),
        .coin_val      (coin_val),
        .confirm       (confirm),
        .cancel        (cancel),
        .price_tbl     (price_tbl),
        .change_ready  (change_ready),
        .stock_restock (stock_restock),
        .goods_index   (goods_index),
        .money         (money),
        .enough_flag   (enough_flag),
        .money_flag    (money_flag),
        .vend_valid    (vend_valid),
        .vend_idx      (vend_idx),
        .change_valid  (change_valid),
        .change_coin   (change_coin),
        .coin_reject   (coin_reject),
        .sold_out      (sold_out),
        .busy          (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic put_coin(input int v);
        coin_valid = 1'b1;
        coin_val   = MW'(v);
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic put_sel(input int i);
        sel_valid = 1'b1;
        sel_idx   = IW'(i);
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic put_confirm();
        confirm = 1'b1;
        tick();
        confirm = 1'b0;
    endtask

    task automatic put_cancel();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
    endtask

    // Greedy reference: called while CHANGE is active, drains with ready high.
    task automatic drain(input int total);
        int rem;
        int exp_c;
        rem = total;
        change_ready = 1'b1;
        for (int k = 0; k < 40 && rem > 0; k++) begin
            exp_c = (rem >= 10) ? 10 : (rem >= 5) ? 5 : 1;
            chk("chg_valid", change_valid, 1);
            chk("chg_coin", change_coin, exp_c);
            chk("chg_money", money, rem);
            rem = rem - exp_c;
            tick();
        end
        change_ready = 1'b0;
        chk("chg_done_valid", change_valid, 0);
        chk("chg_done_money", money, 0);
        chk("chg_done_flag", money_flag, 0);
    endtask

    initial begin
        sys_rst = 1'b1;
        sel_valid = 1'b0; sel_idx = '0; coin_valid = 1'b0; coin_val = '0;
        confirm = 1'b0; cancel = 1'b0; change_ready = 1'b0; stock_restock = 1'b0;
        for (int i = 0; i < NG; i++) price_tbl[i*MW +: MW] = 7'd30;
        price_tbl[0*MW +: MW] = 7'd40;
        price_tbl[2*MW +: MW] = 7'd10;
        price_tbl[3*MW +: MW] = 7'd25;
        price_tbl[5*MW +: MW] = 7'd40;

        repeat (2) tick();
        chk("rst_goods", goods_index, 0);
        chk("rst_money", money, 0);
        chk("rst_flag", money_flag, 0);
        chk("rst_busy", busy, 0);
        chk("rst_vend", vend_valid, 0);
        chk("rst_chg", change_valid, 0);
        chk("rst_coin", change_coin, 0);
        sys_rst = 1'b0;
        tick();

        // Item 3 at 25, pay 30, expect one vend and a single 5 in change.
        put_sel(3);
        chk("t1_goods", goods_index, 3);
        chk("t1_flag_low", money_flag, 1);
        put_coin(10); put_coin(10); put_coin(10);
        chk("t1_money", money, 30);
        chk("t1_enough", enough_flag, 1);
        chk("t1_flag_ok", money_flag, 2);
        put_confirm();
        chk("t1_vend", vend_valid, 1);
        chk("t1_vidx", vend_idx, 3);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_vend_off", vend_valid, 0);
        chk("t1_chg_flag", money_flag, 3);
        drain(5);
        chk("t1_goods_keep", goods_index, 3);

        // Saturation at 95 then cancel refund.
        put_coin(50); put_coin(45);
        chk("t2_money", money, 95);
        put_coin(10);
        chk("t2_reject", coin_reject, 1);
        chk("t2_money_keep", money, 95);
        tick();
        chk("t2_reject_off", coin_reject, 0);
        put_cancel();
        drain(95);

        // Exact ceiling accepted, one more refused.
        put_coin(50); put_coin(49);
        chk("t2b_money", money, 99);
        chk("t2b_noreject", coin_reject, 0);
        put_coin(1);
        chk("t2b_reject", coin_reject, 1);
        chk("t2b_money_keep", money, 99);
        put_cancel();
        drain(99);

        // Insufficient confirm, reselect, then exact payment.
        put_sel(3);
        put_sel(0);
        chk("t3_reselect", goods_index, 0);
        put_coin(20);
        put_confirm();
        chk("t3_stay_flag", money_flag, 1);
        chk("t3_novend", vend_valid, 0);
        chk("t3_notbusy", busy, 0);
        put_coin(20);
        chk("t3_flag_ok", money_flag, 2);
        put_confirm();
        chk("t3_vend", vend_valid, 1);
        chk("t3_vidx", vend_idx, 0);
        tick();
        chk("t3_nochg", change_valid, 0);
        chk("t3_money", money, 0);
        chk("t3_idle", money_flag, 0);
        tick();
        chk("t3_nochg2", change_valid, 0);

        // Same-cycle priority: confirm sees pre-coin credit, sel is dropped.
        put_sel(5);
        put_coin(20); put_coin(15);
        confirm = 1'b1; coin_valid = 1'b1; coin_val = 7'd5; sel_valid = 1'b1; sel_idx = 4'd9;
        tick();
        confirm = 1'b0; coin_valid = 1'b0; sel_valid = 1'b0;
        chk("p_novend", vend_valid, 0);
        chk("p_money", money, 40);
        chk("p_goods", goods_index, 5);
        chk("p_flag", money_flag, 2);
        confirm = 1'b1; coin_valid = 1'b1; coin_val = 7'd7;
        tick();
        confirm = 1'b0; coin_valid = 1'b0;
        chk("p_vend", vend_valid, 1);
        chk("p_vidx", vend_idx, 5);
        chk("p_money_coin", money, 47);
        tick();
        drain(7);
        cancel = 1'b1; coin_valid = 1'b1; coin_val = 7'd8;
        tick();
        cancel = 1'b0; coin_valid = 1'b0;
        drain(8);

        // Cancel with no credit returns to IDLE without change.
        put_sel(1);
        chk("c0_sel", money_flag, 1);
        put_cancel();
        chk("c0_idle", money_flag, 0);
        chk("c0_nochg", change_valid, 0);

        // Idle timeout with 7 credited.
        put_coin(5); put_coin(1); put_coin(1);
        repeat (99) tick();
        chk("to_early", change_valid, 0);
        chk("to_money", money, 7);
        tick();
        chk("to_fire", change_valid, 1);
        chk("to_flag", money_flag, 3);
        drain(7);

        // Stock: item 2 at 10, one unit.
        put_coin(10);
        put_sel(2);
        put_confirm();
        chk("s_vend", vend_valid, 1);
        chk("s_vidx", vend_idx, 2);
        tick();
        chk("s_idle", money_flag, 0);
        put_sel(2);
`ifdef VEND_STOCK_EN
        chk("s_soldout", sold_out, 1);
        chk("s_stay_idle", money_flag, 0);
`else
        chk("s_soldout", sold_out, 0);
        chk("s_sel", money_flag, 1);
`endif
        tick();
        chk("s_soldout_off", sold_out, 0);
        stock_restock = 1'b1;
        tick();
        stock_restock = 1'b0;
        put_sel(2);
        chk("s_restock_sel", money_flag, 1);
        chk("s_restock_goods", goods_index, 2);
        chk("s_restock_nosold", sold_out, 0);
        put_cancel();
        chk("s_back_idle", money_flag, 0);

        // Back-pressure then reset mid-refund.
        put_coin(20);
        put_cancel();
        chk("bp_coin", change_coin, 10);
        coin_valid = 1'b1; coin_val = 7'd5;
        tick();
        coin_valid = 1'b0;
        chk("bp_reject", coin_reject, 1);
        chk("bp_money", money, 20);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("bp_hold_coin", change_coin, 10);
            chk("bp_hold_money", money, 20);
            chk("bp_hold_valid", change_valid, 1);
        end
        change_ready = 1'b1;
        tick();
        change_ready = 1'b0;
        chk("bp_step", money, 10);
        chk("bp_step_coin", change_coin, 10);
        sys_rst = 1'b1;
        #2;
        chk("ar_money", money, 0);
        chk("ar_chg", change_valid, 0);
        chk("ar_flag", money_flag, 0);
        chk("ar_busy", busy, 0);
        tick();
        sys_rst = 1'b0;
        tick();
        chk("ar_idle", money_flag, 0);
        chk("ar_money2", money, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
